// File: rtl/cw_sequencer_pkg.sv
// Shared types and constants for the control-word sequencer:
// state encoding, mux select codes and the default fetch/NOP words.
package cw_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WAIT  = 2'd3
  } state_e;

  localparam logic [1:0] SEL_NOP     = 2'b00;
  localparam logic [1:0] SEL_FETCH   = 2'b01;
  localparam logic [1:0] SEL_EXEC    = 2'b10;
  localparam logic [1:0] SEL_NOP_ALT = 2'b11;

  localparam int          CW_WIDTH_DEF = 47;
  localparam logic [46:0] FETCH_CW_DEF = 47'h2000_1082_0000;
  localparam logic [46:0] NOP_CW_DEF   = 47'h0;

endpackage

// File: rtl/cw_mux4.sv
// Parametrised-width 4:1 word mux used to pick the datapath control word.
module cw_mux4
  import cw_seq_pkg::*;
#(
  parameter int N = CW_WIDTH_DEF
) (
  input  logic [1:0]   S,
  input  logic [N-1:0] I0,
  input  logic [N-1:0] I1,
  input  logic [N-1:0] I2,
  input  logic [N-1:0] I3,
  output logic [N-1:0] Y
);

  always_comb begin
    Y = I0;
    case (S)
      SEL_NOP:     Y = I0;
      SEL_FETCH:   Y = I1;
      SEL_EXEC:    Y = I2;
      SEL_NOP_ALT: Y = I3;
      default:     Y = I0;
    endcase
  end

endmodule

// File: rtl/cw_sequencer.sv
// Multi-cycle control-word sequencer: issues the fetch word, then 1..MAX_PHASES
// decoder-supplied execute words per instruction, with stall, flush and retire count.
module cw_sequencer
  import cw_seq_pkg::*;
#(
  parameter int                  CW_WIDTH   = CW_WIDTH_DEF,
  parameter int                  MAX_PHASES = 4,
  parameter int                  PHASE_W    = (MAX_PHASES > 1) ? $clog2(MAX_PHASES) : 1,
  parameter logic [CW_WIDTH-1:0] FETCH_CW   = FETCH_CW_DEF,
  parameter logic [CW_WIDTH-1:0] NOP_CW     = NOP_CW_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall,
  input  logic                flush,
  input  logic                instr_valid,
  input  logic [CW_WIDTH-1:0] exec_cw,
  input  logic [PHASE_W:0]    exec_phases,
  output logic [CW_WIDTH-1:0] cw_out,
  output logic [PHASE_W-1:0]  phase_idx,
  output logic                fetch_strobe,
  output logic                instr_done,
  output logic [1:0]          state,
  output logic [15:0]         instr_count
);

  localparam logic [PHASE_W:0]   MAX_P   = (PHASE_W+1)'(MAX_PHASES);
  localparam logic [PHASE_W:0]   ONE_EXT = (PHASE_W+1)'(1);
  localparam logic [PHASE_W-1:0] PH_ONE  = PHASE_W'(1);

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [15:0]        count_q, count_d;
  logic [1:0]         sel;
  logic               done;
  logic               fstrobe;
  logic [PHASE_W:0]   n_eff;
  logic [PHASE_W:0]   phase_next_ext;
  logic               last_phase;

  // Zero phases means one; anything above MAX_PHASES saturates.
  always_comb begin
    n_eff = exec_phases;
    if (exec_phases == '0) begin
      n_eff = ONE_EXT;
    end else if (exec_phases > MAX_P) begin
      n_eff = MAX_P;
    end
  end

  // Using >= lets a shrinking exec_phases retire the instruction immediately.
  assign phase_next_ext = {1'b0, phase_q} + ONE_EXT;
  assign last_phase     = (phase_next_ext >= n_eff);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    count_d = count_q;
    sel     = SEL_NOP;
    done    = 1'b0;
    fstrobe = 1'b0;
    if (flush) begin
      state_d = ST_FETCH;
      phase_d = '0;
    end else if (!stall) begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_FETCH;
          phase_d = '0;
        end
        ST_FETCH: begin
          sel     = SEL_FETCH;
          fstrobe = 1'b1;
          state_d = ST_EXEC;
          phase_d = '0;
        end
        ST_EXEC, ST_WAIT: begin
          if (!instr_valid) begin
            state_d = ST_WAIT;
          end else begin
            sel     = SEL_EXEC;
            state_d = ST_EXEC;
            if (last_phase) begin
              done    = 1'b1;
              count_d = count_q + 16'd1;
              state_d = ST_FETCH;
              phase_d = '0;
            end else begin
              phase_d = phase_q + PH_ONE;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          phase_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      count_q <= count_d;
    end
  end

  cw_mux4 #(
    .N(CW_WIDTH)
  ) u_cw_mux (
    .S (sel),
    .I0(NOP_CW),
    .I1(FETCH_CW),
    .I2(exec_cw),
    .I3(NOP_CW),
    .Y (cw_out)
  );

  assign phase_idx    = phase_q;
  assign fetch_strobe = fstrobe;
  assign instr_done   = done;
  assign state        = state_q;
  assign instr_count  = count_q;

endmodule

// File: tb/tb_cw_sequencer.sv
// Directed, table-driven bench for cw_sequencer: one row per clock cycle,
// plus hand-written sequences for phase-count shrink and retire-count wrap.
module tb_cw_sequencer;

  localparam logic [46:0] F  = 47'h2000_1082_0000;
  localparam logic [46:0] NP = 47'h0;
  localparam logic [46:0] A  = 47'h0A00_0000_1111;
  localparam logic [46:0] B  = 47'h0B00_0000_2222;
  localparam logic [46:0] C  = 47'h0C00_0000_3333;
  localparam logic [46:0] D  = 47'h0D00_0000_4444;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic        instr_valid;
  logic [46:0] exec_cw;
  logic [2:0]  exec_phases;
  logic [46:0] cw_out;
  logic [1:0]  phase_idx;
  logic        fetch_strobe;
  logic        instr_done;
  logic [1:0]  state;
  logic [15:0] instr_count;

  int n_chk;
  int n_fail;

  cw_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .stall       (stall),
    .flush       (flush),
    .instr_valid (instr_valid),
    .exec_cw     (exec_cw),
    .exec_phases (exec_phases),
    .cw_out      (cw_out),
    .phase_idx   (phase_idx),
    .fetch_strobe(fetch_strobe),
    .instr_done  (instr_done),
    .state       (state),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic        s;
    logic        f;
    logic        v;
    logic [2:0]  ph;
    logic [46:0] cw;
    logic [46:0] e_cw;
    logic        e_fs;
    logic        e_done;
    logic [1:0]  e_st;
    logic [1:0]  e_pi;
    logic [15:0] e_cnt;
  } vec_t;

  localparam int NV = 33;
  vec_t vt[NV];

  function automatic vec_t mk(input logic r, s, f, v, input logic [2:0] ph,
                              input logic [46:0] cw, e_cw, input logic e_fs, e_done,
                              input logic [1:0] e_st, e_pi, input logic [15:0] e_cnt);
    vec_t t;
    t.r = r; t.s = s; t.f = f; t.v = v; t.ph = ph; t.cw = cw;
    t.e_cw = e_cw; t.e_fs = e_fs; t.e_done = e_done;
    t.e_st = e_st; t.e_pi = e_pi; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic chk_all(input int row, input logic [46:0] e_cw, input logic e_fs, input logic e_done,
                         input logic [1:0] e_st, input logic [1:0] e_pi, input logic [15:0] e_cnt);
    chk("cw_out", row, 64'(cw_out), 64'(e_cw));
    chk("fetch_strobe", row, 64'(fetch_strobe), 64'(e_fs));
    chk("instr_done", row, 64'(instr_done), 64'(e_done));
    chk("state", row, 64'(state), 64'(e_st));
    chk("phase_idx", row, 64'(phase_idx), 64'(e_pi));
    chk("instr_count", row, 64'(instr_count), 64'(e_cnt));
    $display("row %0d: cw_out=%h fs=%0b done=%0b state=%0d phase=%0d count=%0h",
             row, cw_out, fetch_strobe, instr_done, state, phase_idx, instr_count);
  endtask

  task automatic drive(input logic r, s, f, v, input logic [2:0] ph, input logic [46:0] cw);
    rst_n = r; stall = s; flush = f; instr_valid = v; exec_phases = ph; exec_cw = cw;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    //            r  s  f  v  ph  cw   | e_cw fs done st pi cnt
    vt[0]  = mk(0, 0, 0, 0, 0, NP,  NP, 0, 0, 0, 0, 16'd0);  // held in reset
    vt[1]  = mk(1, 0, 0, 0, 0, NP,  NP, 0, 0, 0, 0, 16'd0);  // IDLE
    vt[2]  = mk(1, 0, 0, 1, 3, A,   F,  1, 0, 1, 0, 16'd0);  // FETCH
    vt[3]  = mk(1, 0, 0, 1, 3, A,   A,  0, 0, 2, 0, 16'd0);
    vt[4]  = mk(1, 0, 0, 1, 3, B,   B,  0, 0, 2, 1, 16'd0);
    vt[5]  = mk(1, 0, 0, 1, 3, C,   C,  0, 1, 2, 2, 16'd0);
    vt[6]  = mk(1, 0, 0, 1, 3, A,   F,  1, 0, 1, 0, 16'd1);  // back-to-back FETCH
    vt[7]  = mk(1, 0, 0, 1, 3, A,   A,  0, 0, 2, 0, 16'd1);
    vt[8]  = mk(1, 1, 0, 1, 3, B,   NP, 0, 0, 2, 1, 16'd1);  // stall x2 at phase 1
    vt[9]  = mk(1, 1, 0, 1, 3, B,   NP, 0, 0, 2, 1, 16'd1);
    vt[10] = mk(1, 0, 0, 1, 3, B,   B,  0, 0, 2, 1, 16'd1);
    vt[11] = mk(1, 0, 0, 1, 3, C,   C,  0, 1, 2, 2, 16'd1);
    vt[12] = mk(1, 0, 0, 1, 4, A,   F,  1, 0, 1, 0, 16'd2);
    vt[13] = mk(1, 0, 0, 1, 4, A,   A,  0, 0, 2, 0, 16'd2);
    vt[14] = mk(1, 0, 0, 1, 4, B,   B,  0, 0, 2, 1, 16'd2);
    vt[15] = mk(1, 1, 1, 1, 4, C,   NP, 0, 0, 2, 2, 16'd2);  // flush + stall at phase 2 of 4
    vt[16] = mk(1, 0, 0, 1, 0, A,   F,  1, 0, 1, 0, 16'd2);
    vt[17] = mk(1, 0, 0, 1, 0, A,   A,  0, 1, 2, 0, 16'd2);  // exec_phases=0 -> one EXEC
    vt[18] = mk(1, 0, 0, 1, 7, A,   F,  1, 0, 1, 0, 16'd3);
    vt[19] = mk(1, 0, 0, 1, 7, A,   A,  0, 0, 2, 0, 16'd3);  // exec_phases=7 -> four EXEC
    vt[20] = mk(1, 0, 0, 1, 7, B,   B,  0, 0, 2, 1, 16'd3);
    vt[21] = mk(1, 0, 0, 1, 7, C,   C,  0, 0, 2, 2, 16'd3);
    vt[22] = mk(1, 0, 0, 1, 7, D,   D,  0, 1, 2, 3, 16'd3);
    vt[23] = mk(1, 0, 0, 0, 1, A,   F,  1, 0, 1, 0, 16'd4);
    vt[24] = mk(1, 0, 0, 0, 1, A,   NP, 0, 0, 2, 0, 16'd4);  // invalid -> WAIT
    vt[25] = mk(1, 0, 0, 0, 1, A,   NP, 0, 0, 3, 0, 16'd4);
    vt[26] = mk(1, 0, 0, 1, 1, A,   A,  0, 1, 3, 0, 16'd4);  // WAIT acts as EXEC
    vt[27] = mk(1, 1, 0, 1, 1, A,   NP, 0, 0, 1, 0, 16'd5);  // stall in FETCH
    vt[28] = mk(1, 0, 0, 1, 3, A,   F,  1, 0, 1, 0, 16'd5);
    vt[29] = mk(1, 0, 0, 1, 3, A,   A,  0, 0, 2, 0, 16'd5);
    vt[30] = mk(0, 0, 0, 1, 3, B,   B,  0, 0, 2, 1, 16'd5);  // reset mid-EXEC
    vt[31] = mk(1, 0, 0, 0, 0, NP,  NP, 0, 0, 0, 0, 16'd0);
    vt[32] = mk(1, 0, 0, 1, 3, A,   F,  1, 0, 1, 0, 16'd0);

    drive(0, 0, 0, 0, 0, NP);
    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].r, vt[i].s, vt[i].f, vt[i].v, vt[i].ph, vt[i].cw);
      #1;
      chk_all(i, vt[i].e_cw, vt[i].e_fs, vt[i].e_done, vt[i].e_st, vt[i].e_pi, vt[i].e_cnt);
    end

    // exec_phases shrinks below phase_idx+1 mid-instruction: retires at once.
    @(negedge clk);
    drive(1, 0, 0, 1, 3, A);
    #1;
    chk_all(100, A, 0, 0, 2, 0, 16'd0);
    @(negedge clk);
    drive(1, 0, 0, 1, 1, B);
    #1;
    chk_all(101, B, 0, 1, 2, 1, 16'd0);

    // Retire counter wraps from FFFF to 0.
    @(negedge clk);
    drive(1, 0, 0, 1, 1, C);
    force dut.count_q = 16'hFFFF;
    #1;
    release dut.count_q;
    #1;
    chk_all(102, F, 1, 0, 1, 0, 16'hFFFF);
    @(negedge clk);
    #1;
    chk_all(103, C, 0, 1, 2, 0, 16'hFFFF);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, C);
    #1;
    chk_all(104, F, 1, 0, 1, 0, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
